// File: rtl/pattern_detect_pkg.sv
// Shared defaults and sizing helper for the serial pattern detector.
package pattern_detect_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;
  localparam logic [31:0] DEF_RST_PAT = 32'b00010010;
  localparam int DEF_RST_LEN = 5;
  localparam bit DEF_RST_OVL = 1'b1;

  // Width needed to hold a length value 0..max_len inclusive.
  function automatic int len_width(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/pattern_detect_sat_counter.sv
// Width-parameterised saturating up-counter; clear takes priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pattern_detect.sv
// Serial bit-pattern detector with runtime-loadable pattern, length and overlap mode.
module pattern_detect
  import pattern_detect_pkg::*;
#(
  parameter int                 MAX_LEN = DEF_MAX_LEN,
  parameter int                 CNT_W   = DEF_CNT_W,
  parameter logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(DEF_RST_PAT),
  parameter int                 RST_LEN = DEF_RST_LEN,
  parameter bit                 RST_OVL = DEF_RST_OVL
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           x,
  input  logic                           in_valid,
  input  logic                           pat_load,
  input  logic [MAX_LEN-1:0]             pat_in,
  input  logic [len_width(MAX_LEN)-1:0]  len_in,
  input  logic                           ovl_in,
  input  logic                           cnt_clr,
  output logic                           z,
  output logic [CNT_W-1:0]               match_cnt,
  output logic                           primed
);

  localparam int LEN_W = len_width(MAX_LEN);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] hist_q, hist_d, pat_q, pat_d;
  logic [LEN_W-1:0]   fill_q, fill_d, len_q, len_d;
  logic               ovl_q, ovl_d, z_q, z_d;
  logic [MAX_LEN-1:0] hist_shift, len_mask;
  logic               accept, fill_ok, hist_eq, match;

  // Only the low len bits of pattern and history take part in the compare.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
    assign len_mask[gi] = (LEN_W'(gi) < len_q);
  end

  assign hist_shift = {hist_q[MAX_LEN-2:0], x};
  assign accept     = in_valid && !pat_load;
  assign fill_ok    = ({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q};
  assign hist_eq    = ((hist_shift ^ pat_q) & len_mask) == '0;
  assign match      = accept && (len_q != '0) && fill_ok && hist_eq;

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    z_d    = match;
    if (pat_load) begin
      pat_d  = pat_in;
      len_d  = (len_in > MAX_LEN_L) ? MAX_LEN_L : len_in;
      ovl_d  = ovl_in;
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      hist_d = hist_shift;
      // Non-overlap mode restarts the fill so the next match needs len fresh bits.
      if (match && !ovl_q) begin
        fill_d = '0;
      end else if (fill_q != MAX_LEN_L) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= RST_PAT;
      len_q  <= LEN_W'(RST_LEN);
      ovl_q  <= RST_OVL;
      z_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      z_q    <= z_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (match),
    .clr (cnt_clr),
    .cnt (match_cnt)
  );

  assign z      = z_q;
  assign primed = (len_q != '0) && (fill_q >= len_q);

endmodule

// File: tb/tb_pattern_detect.sv
// Scoreboard bench: stimulus pushes model expectations, monitor checks each cycle.
module tb_pattern_detect;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       x = 1'b0, in_valid = 1'b0, pat_load = 1'b0, ovl_in = 1'b0, cnt_clr = 1'b0;
  logic [7:0] pat_in = '0;
  logic [3:0] len_in = '0;
  logic       z, primed, z2, primed2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  always #5 clk = ~clk;

  pattern_detect dut (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .pat_load(pat_load),
    .pat_in(pat_in), .len_in(len_in), .ovl_in(ovl_in), .cnt_clr(cnt_clr),
    .z(z), .match_cnt(match_cnt), .primed(primed)
  );

  pattern_detect #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .pat_load(pat_load),
    .pat_in(pat_in), .len_in(len_in), .ovl_in(ovl_in), .cnt_clr(cnt_clr),
    .z(z2), .match_cnt(match_cnt2), .primed(primed2)
  );

  typedef struct {
    logic       z;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    logic       primed;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: bits received since the last clear, newest at the back.
  bit         m_bits[$];
  logic [7:0] m_pat;
  int         m_len, m_cnt, m_cnt2;
  bit         m_ovl, m_z;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  function automatic bit tail_matches();
    if (m_len == 0 || m_bits.size() < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++)
      if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input bit r, input bit xb, input bit v, input bit ld,
                            input logic [7:0] pin, input int lin, input bit oin, input bit clr);
    bit m = 1'b0;
    if (r) begin
      m_bits.delete();
      m_pat = 8'b00010010; m_len = 5; m_ovl = 1'b1;
      m_cnt = 0; m_cnt2 = 0; m_z = 1'b0;
      return;
    end
    if (ld) begin
      m_pat = pin; m_len = (lin > 8) ? 8 : lin; m_ovl = oin;
      m_bits.delete();
    end else if (v) begin
      m_bits.push_back(xb);
      if (m_bits.size() > 8) void'(m_bits.pop_front());
      m = tail_matches();
      if (m && !m_ovl) m_bits.delete();
    end
    m_z = m;
    if (clr) begin
      m_cnt = 0; m_cnt2 = 0;
    end else if (m) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  task automatic step(input bit r, input bit xb, input bit v, input bit ld,
                      input logic [7:0] pin, input int lin, input bit oin, input bit clr);
    exp_t e;
    @(negedge clk);
    rst = r; x = xb; in_valid = v; pat_load = ld;
    pat_in = pin; len_in = 4'(lin); ovl_in = oin; cnt_clr = clr;
    model_step(r, xb, v, ld, pin, lin, oin, clr);
    e.z = m_z; e.cnt = 8'(m_cnt); e.cnt2 = 2'(m_cnt2);
    e.primed = (m_len != 0) && (m_bits.size() >= m_len);
    sb.push_back(e);
  endtask

  task automatic do_rst();               step(1, 0, 0, 0, 8'h00, 0, 0, 0); endtask
  task automatic bit_in(input bit b);    step(0, b, 1, 0, 8'h00, 0, 0, 0); endtask
  task automatic idle();                 step(0, 0, 0, 0, 8'h00, 0, 0, 0); endtask
  task automatic load(input logic [7:0] p, input int l, input bit o);
    step(0, 0, 0, 1, p, l, o, 0);
  endtask
  task automatic send(input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) bit_in(bits[i]);
  endtask

  // Direct constant check of the outputs produced by the edge just issued.
  task automatic dchk(input string name, input bit wz, input int wcnt);
    @(posedge clk); #1;
    chk({name, "_z"}, int'(z), int'(wz));
    chk({name, "_cnt"}, int'(match_cnt), wcnt);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("z", int'(z), int'(e.z));
        chk("match_cnt", int'(match_cnt), int'(e.cnt));
        chk("match_cnt_w2", int'(match_cnt2), int'(e.cnt2));
        chk("primed", int'(primed), int'(e.primed));
        chk("z_w2", int'(z2), int'(e.z));
      end
    end
  end

  initial begin : stim
    do_rst();
    dchk("reset", 0, 0);
    chk("reset_primed", int'(primed), 0);

    send(8'b10010, 5);
    dchk("basic", 1, 1);

    do_rst();
    send(8'b10010010, 8);
    dchk("overlap", 1, 2);
    load(8'h12, 5, 0);
    send(8'b10010010, 8);
    dchk("nonoverlap", 0, 3);

    load(8'h07, 3, 1);
    send(8'b11111, 5);
    dchk("ones_ovl", 1, 6);
    load(8'h07, 3, 0);
    send(8'b11111, 5);
    dchk("ones_novl", 0, 7);

    do_rst();
    for (int i = 4; i >= 0; i--) begin
      bit_in(8'(5'b10010) >> i);
      idle();
    end
    chk("gapped_primed", int'(primed), 1);
    chk("gapped_cnt", int'(match_cnt), 1);

    load(8'h01, 1, 1);
    send(8'b11111, 5);
    step(0, 1, 1, 0, 8'h00, 0, 0, 1);
    dchk("clr_vs_match", 1, 0);
    chk("clr_vs_match_w2", int'(match_cnt2), 0);

    do_rst();
    send(8'b1001, 4);
    load(8'h12, 5, 1);
    bit_in(1'b0);
    dchk("load_breaks", 0, 0);
    send(8'b1001, 4);
    do_rst();
    bit_in(1'b0);
    dchk("rst_breaks", 0, 0);

    load(8'hA5, 0, 1);
    send(8'b00000000, 8);
    chk("len0_primed", int'(primed), 0);
    load(8'hFF, 12, 0);
    send(8'b11111111, 8);
    dchk("len_clamp", 1, 1);

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_rst();
      end else if ($urandom_range(0, 59) == 0) begin
        step(0, 1'($urandom), 1'($urandom), 1, 8'($urandom),
             ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4),
             1'($urandom), ($urandom_range(0, 39) == 0));
      end else begin
        step(0, 1'($urandom), ($urandom_range(0, 3) != 0), 0, 8'($urandom),
             $urandom_range(0, 15), 1'($urandom), ($urandom_range(0, 39) == 0));
      end
    end

    idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_detect.md
PATTERN_DETECT -- requirements
Module: pattern_detect

Interface
REQ-001 Parameter MAX_LEN, default 8, maximum pattern length in bits (legal range 2..32).
REQ-002 Parameter CNT_W, default 8, width of the match counter.
REQ-003 Parameter RST_PAT, default 8'b00010010, pattern loaded at reset.
REQ-004 Parameter RST_LEN, default 5, pattern length loaded at reset.
REQ-005 Parameter RST_OVL, default 1, overlap mode loaded at reset.
REQ-006 Port list SHALL be exactly the following; one clock; reset is synchronous and active-high.
REQ-007 clk  input  1  sole clock, all state updates on its rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 x  input  1  serial data bit.
REQ-010 in_valid  input  1  x is accepted on this edge when high.
REQ-011 pat_load  input  1  load pat_in/len_in/ovl_in this edge.
REQ-012 pat_in  input  MAX_LEN  new pattern; bit len-1 is the first bit received, bit 0 the last.
REQ-013 len_in  input  $clog2(MAX_LEN)+1  new pattern length.
REQ-014 ovl_in  input  1  new overlap mode (1 = overlapping matches allowed).
REQ-015 cnt_clr  input  1  clear match counter.
REQ-016 z  output  1  registered one-cycle match pulse.
REQ-017 match_cnt  output  CNT_W  saturating count of matches.
REQ-018 primed  output  1  enough bits held to match (fill >= len and len != 0).

Function
REQ-019 Internal state: history shift register hist[MAX_LEN-1:0], fill counter (saturating at MAX_LEN), pat, len, ovl registers.
REQ-020 Accepted bit (in_valid=1, pat_load=0): hist <= {hist[MAX_LEN-2:0], x}; fill <= min(fill+1, MAX_LEN).
REQ-021 Match event at an edge SHALL occur iff a bit is accepted, len != 0, fill+1 >= len, and the updated hist[len-1:0] equals pat[len-1:0].
REQ-022 z SHALL be 1 in exactly the cycle after a match event edge and 0 otherwise; cycles with in_valid=0 never assert z.
REQ-023 Non-overlap mode (ovl=0): on a match event fill SHALL be cleared to 0 so the next match needs len fresh bits.
REQ-024 Overlap mode (ovl=1): fill is unaffected by a match.
REQ-025 match_cnt SHALL increment by 1 per match event and hold at 2^CNT_W-1.
REQ-026 cnt_clr SHALL set match_cnt to 0 and wins over a simultaneous match; z still pulses.
REQ-027 pat_load SHALL capture pat_in, ovl_in, and len_in clamped to MAX_LEN; clear hist and fill; a simultaneous in_valid bit is discarded and no match occurs that edge.
REQ-028 len = 0 SHALL disable matching; primed stays 0.
REQ-029 pat bits above len-1 SHALL be ignored.
REQ-030 pat_load SHALL NOT alter match_cnt.

Reset
REQ-031 rst SHALL set z=0, match_cnt=0, hist=0, fill=0, pat=RST_PAT, len=RST_LEN, ovl=RST_OVL; rst overrides all other inputs.
REQ-032 rst asserted mid-stream SHALL discard partial history; the first match after reset needs len new bits.

Structure
REQ-033 Shared package pattern_detect_pkg SHALL hold the default parameter constants and the length-width helper.
REQ-034 Match counter SHALL be a sub-module sat_counter (width-parameterised, inc/clr, clr priority).
REQ-035 Output z and match_cnt SHALL be driven directly from flops; no combinational path from inputs to outputs except none for primed (flop-derived).

Verification
REQ-036 After rst, stream 1,0,0,1,0 (in_valid=1 each cycle) -> z=1 only in cycle after 5th bit, match_cnt=1.
REQ-037 Default pattern, stream 1,0,0,1,0,0,1,0 -> z after bits 5 and 8, match_cnt=2; reload with ovl_in=0 and repeat -> only bit 5 matches.
REQ-038 Load pat_in=8'h07, len_in=3, ovl_in=1; stream 1,1,1,1,1 -> matches at bits 3,4,5 (count 3); with ovl_in=0 -> match at bit 3 only.
REQ-039 Default pattern with in_valid low between each bit -> same single match, z never high in idle cycles, primed rises after 5th accepted bit.
REQ-040 CNT_W=2, five matches -> match_cnt=3; cnt_clr coincident with a match -> match_cnt=0, z=1.
REQ-041 Send 1,0,0,1 then pat_load (same pattern) then 0 -> no match; rst after 1,0,0,1 then 0 -> no match, outputs at reset values.
